symme_timer_mc: RTL and testbench

Parametrised multi-mode timer generalising the symmetric up/down timer: one WIDTH-bit counter running in up-sawtooth, down-sawtooth or symmetric (triangle) mode, with NCMP compare channels producing PWM outputs and a one-cycle period-end pulse. Configuration is double-buffered, so cfg_* changes take effect only at a period boundary. An optional one-shot mode stops the timer after a single period. Sits beside the existing timers as the PWM/time-base source for motor and LED drivers.

---
 rtl/symme_timer_mc.sv | 141 ++++++++++++++
 tb/tb_symme_timer_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/symme_timer_mc.sv
// Multi-mode PWM time base: up, down or symmetric counter with NCMP compare
// channels, double-buffered configuration and an optional one-shot period.
module symme_timer_mc #(
  parameter int WIDTH = 32,
  parameter int NCMP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            cfg_mode,
  input  logic [WIDTH-1:0]      cfg_max,
  input  logic [NCMP*WIDTH-1:0] cfg_cmp,
  input  logic                  cfg_oneshot,
  output logic [WIDTH-1:0]      cnt,
  output logic                  dir,
  output logic                  active,
  output logic                  prd_pulse,
  output logic [NCMP-1:0]       pwm_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0]       M_UP  = 2'd0;
  localparam logic [1:0]       M_DN  = 2'd1;
  localparam logic [1:0]       M_SYM = 2'd2;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  function automatic logic [WIDTH-1:0] norm_max(input logic [WIDTH-1:0] m);
    return (m == '0) ? ONE : m;
  endfunction

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? M_SYM : m;
  endfunction

  state_t                  state;
  logic [WIDTH-1:0]        max_s;
  logic [1:0]              mode_s;
  logic [NCMP*WIDTH-1:0]   cmp_s;
  logic                    os_s;

  logic [WIDTH-1:0]        ld_max;
  logic [1:0]              ld_mode;
  logic [WIDTH-1:0]        ld_cnt;
  logic                    ld_dir;
  logic                    term;

  // Values a period boundary loads: new shadows plus the new mode's start point.
  always_comb begin
    ld_max  = norm_max(cfg_max);
    ld_mode = norm_mode(cfg_mode);
    ld_cnt  = (ld_mode == M_DN) ? ld_max : '0;
    ld_dir  = (ld_mode == M_DN);
  end

  always_comb begin
    term = 1'b0;
    case (mode_s)
      M_UP:    term = (cnt == max_s);
      M_DN:    term = (cnt == '0);
      default: term = dir && (cnt == ONE);
    endcase
  end

  assign active    = (state == RUN);
  assign prd_pulse = active && term;

  always_comb begin
    pwm_out = '0;
    for (int i = 0; i < NCMP; i++)
      pwm_out[i] = active && (cnt < cmp_s[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dir    <= 1'b0;
      max_s  <= ONE;
      mode_s <= M_UP;
      cmp_s  <= '0;
      os_s   <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= RUN;
          max_s  <= ld_max;
          mode_s <= ld_mode;
          cmp_s  <= cfg_cmp;
          os_s   <= cfg_oneshot;
          cnt    <= ld_cnt;
          dir    <= ld_dir;
        end
        RUN: begin
          if (term) begin
            if (os_s) begin
              state <= DONE;
              cnt   <= '0;
              dir   <= 1'b0;
            end else begin
              max_s  <= ld_max;
              mode_s <= ld_mode;
              cmp_s  <= cfg_cmp;
              os_s   <= cfg_oneshot;
              cnt    <= ld_cnt;
              dir    <= ld_dir;
            end
          end else begin
            case (mode_s)
              M_UP: cnt <= cnt + ONE;
              M_DN: cnt <= cnt - ONE;
              default: begin
                // Symmetric: turn around on the edge the count reaches the top.
                if (!dir) begin
                  cnt <= cnt + ONE;
                  dir <= ((cnt + ONE) == max_s);
                end else begin
                  cnt <= cnt - ONE;
                end
              end
            endcase
          end
        end
        DONE: begin
          cnt <= '0;
          dir <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          dir   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_symme_timer_mc.sv
// Bench for symme_timer_mc: a period-position reference model checked every
// cycle, directed sequences with literal expectations, then random traffic.
module tb_symme_timer_mc;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst, en, cfg_oneshot;
  logic [1:0]     cfg_mode;
  logic [W-1:0]   cfg_max;
  logic [N*W-1:0] cfg_cmp;
  logic [W-1:0]   cnt;
  logic           dir, active, prd_pulse;
  logic [N-1:0]   pwm_out;

  symme_timer_mc #(.WIDTH(W), .NCMP(N)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_mode(cfg_mode), .cfg_max(cfg_max),
    .cfg_cmp(cfg_cmp), .cfg_oneshot(cfg_oneshot), .cnt(cnt), .dir(dir),
    .active(active), .prd_pulse(prd_pulse), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: state plus position p inside the current period.
  int     m_st = 0;           // 0 idle, 1 run, 2 done
  longint m_max = 1, m_mode = 0, m_os = 0, m_p = 0;
  longint m_cmp [N];

  function automatic longint period();
    return (m_mode == 2) ? 2 * m_max : m_max + 1;
  endfunction

  function automatic longint exp_cnt();
    if (m_st != 1) return 0;
    if (m_mode == 0) return m_p;
    if (m_mode == 1) return m_max - m_p;
    return (m_p <= m_max) ? m_p : 2 * m_max - m_p;
  endfunction

  function automatic longint exp_dir();
    if (m_st != 1) return 0;
    if (m_mode == 1) return 1;
    if (m_mode == 2) return (m_p >= m_max) ? 1 : 0;
    return 0;
  endfunction

  function automatic longint exp_prd();
    return (m_st == 1 && m_p == period() - 1) ? 1 : 0;
  endfunction

  function automatic longint exp_pwm(input int i);
    return (m_st == 1 && exp_cnt() < m_cmp[i]) ? 1 : 0;
  endfunction

  task automatic m_load();
    m_max  = (cfg_max == 0) ? 1 : longint'(cfg_max);
    m_mode = (cfg_mode == 3) ? 2 : longint'(cfg_mode);
    m_os   = longint'(cfg_oneshot);
    for (int i = 0; i < N; i++) m_cmp[i] = longint'(cfg_cmp[i*W +: W]);
    m_p = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_max = 1; m_mode = 0; m_os = 0; m_p = 0;
      for (int i = 0; i < N; i++) m_cmp[i] = 0;
    end else if (!en) begin
      m_st = 0; m_p = 0;
    end else if (m_st == 0) begin
      m_load(); m_st = 1;
    end else if (m_st == 1) begin
      if (m_p == period() - 1) begin
        if (m_os != 0) begin m_st = 2; m_p = 0; end
        else m_load();
      end else begin
        m_p++;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      chk("cnt", longint'(cnt), exp_cnt());
      chk("dir", longint'(dir), exp_dir());
      chk("active", longint'(active), (m_st == 1) ? 1 : 0);
      chk("prd_pulse", longint'(prd_pulse), exp_prd());
      for (int i = 0; i < N; i++) chk("pwm_out", longint'(pwm_out[i]), exp_pwm(i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int md, input int mx, input int c0, input int c1, input bit os);
    en = 1'b0;
    step();
    cfg_mode = 2'(md); cfg_max = W'(mx); cfg_cmp = {W'(c1), W'(c0)}; cfg_oneshot = os;
    en = 1'b1;
  endtask

  int t1c [6] = '{0, 1, 2, 3, 0, 1};
  int t1p [6] = '{0, 0, 0, 1, 0, 0};
  int t1w [6] = '{1, 1, 0, 0, 1, 1};
  int t2c [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int t2d [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
  int t2p [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int t3c [4] = '{1, 0, 1, 0};
  int t3p [4] = '{0, 1, 0, 1};
  int t4c [10] = '{0, 1, 2, 3, 4, 5, 2, 1, 0, 2};
  int t5c [5] = '{0, 1, 2, 0, 0};
  int t5a [5] = '{1, 1, 1, 0, 0};
  int t5p [5] = '{0, 0, 1, 0, 0};

  initial begin
    bit found;
    rst = 1'b1; en = 1'b0; cfg_mode = '0; cfg_max = '0; cfg_cmp = '0; cfg_oneshot = 1'b0;
    step(); step();
    chk_on = 1'b1;
    chk("rst_cnt", longint'(cnt), 0);
    chk("rst_dir", longint'(dir), 0);
    chk("rst_active", longint'(active), 0);
    chk("rst_prd", longint'(prd_pulse), 0);
    chk("rst_pwm", longint'(pwm_out), 0);
    rst = 1'b0;

    go(0, 3, 2, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_cnt", longint'(cnt), t1c[k]);
      chk("t1_mdl_cnt", exp_cnt(), t1c[k]);
      chk("t1_prd", longint'(prd_pulse), t1p[k]);
      chk("t1_pwm0", longint'(pwm_out[0]), t1w[k]);
      chk("t1_pwm1", longint'(pwm_out[1]), 0);
    end

    go(3, 3, 0, 9, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_cnt", longint'(cnt), t2c[k]);
      chk("t2_dir", longint'(dir), t2d[k]);
      chk("t2_mdl_dir", exp_dir(), t2d[k]);
      chk("t2_prd", longint'(prd_pulse), t2p[k]);
      chk("t2_pwm1", longint'(pwm_out[1]), 1);
    end

    go(1, 0, 1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_cnt", longint'(cnt), t3c[k]);
      chk("t3_dir", longint'(dir), 1);
      chk("t3_prd", longint'(prd_pulse), t3p[k]);
      chk("t3_mdl_prd", exp_prd(), t3p[k]);
    end

    go(0, 5, 3, 6, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_cnt", longint'(cnt), t4c[k]);
      chk("t4_mdl_cnt", exp_cnt(), t4c[k]);
      if (k == 2) begin cfg_max = W'(2); cfg_mode = 2'd1; end
    end

    go(0, 2, 1, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_cnt", longint'(cnt), t5c[k]);
      chk("t5_active", longint'(active), t5a[k]);
      chk("t5_prd", longint'(prd_pulse), t5p[k]);
    end
    cfg_oneshot = 1'b0;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    chk("t5_restart_cnt", longint'(cnt), 0);
    chk("t5_restart_active", longint'(active), 1);

    go(2, 7, 3, 8, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (cnt == W'(4)) found = 1'b1;
    end
    chk("t6_reach_cnt4", longint'(found), 1);
    rst = 1'b1; cfg_mode = 2'd1; cfg_max = W'(4);
    step();
    chk("t6_rst_cnt", longint'(cnt), 0);
    chk("t6_rst_dir", longint'(dir), 0);
    chk("t6_rst_active", longint'(active), 0);
    chk("t6_rst_prd", longint'(prd_pulse), 0);
    chk("t6_rst_pwm", longint'(pwm_out), 0);
    rst = 1'b0;
    step();
    chk("t6_reload_cnt", longint'(cnt), 4);
    chk("t6_reload_dir", longint'(dir), 1);
    chk("t6_reload_active", longint'(active), 1);

    repeat (2000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) begin
        cfg_mode    = 2'($urandom_range(0, 3));
        cfg_max     = ($urandom_range(0, 15) == 0) ? W'(255) : W'($urandom_range(0, 10));
        cfg_cmp     = {W'($urandom_range(0, 12)), W'($urandom_range(0, 12))};
        cfg_oneshot = ($urandom_range(0, 9) == 0);
      end
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
